// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game: hole count, scheduler state
// encodings and the mole-placement LFSR.
package whack_pkg;

  // Hole count shared by the game FSM, match logic and the mole scheduler.
  localparam int NUM_HOLES = 5;

  // Galois feedback taps for the 16-bit hole-selection LFSR.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GAP   = 3'd1,
    SPAWN = 3'd2,
    UP    = 3'd3,
    CLEAR = 3'd4
  } moleState_e;

  // One Galois LFSR step; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
    logic [15:0] shifted;
    shifted = cur >> 1;
    if (cur[0]) begin
      return shifted ^ LFSR_TAPS;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/mole_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every DIV clocks.
// A clear restarts the count so the first tick lands DIV cycles later.
module mole_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_r;

  // Prescaler counter: wraps at LAST, restarts on reset or clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= CW'(0);
    end else if (clear) begin
      count_r <= CW'(0);
    end else if (count_r == LAST) begin
      count_r <= CW'(0);
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  // Decoded from the counter register, so the tick is a clean single-cycle pulse.
  assign tick = (count_r == LAST);

endmodule

// File: rtl/mole_scheduler.sv
// Mole scheduler: while the game is running, picks a pseudo-random hole,
// holds the mole up for a level-dependent time, clears it on expiry or on a
// correct hit, and raises the level as correct hits accumulate.
module mole_scheduler #(
  parameter int          NUM_HOLES      = whack_pkg::NUM_HOLES,
  parameter int          CLK_HZ         = 50000000,
  parameter int          TICK_HZ        = 1000,
  parameter int          BASE_UP_MS     = 1000,
  parameter int          MIN_UP_MS      = 300,
  parameter int          STEP_MS        = 100,
  parameter int          GAP_MS         = 250,
  parameter int          HITS_PER_LEVEL = 5,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 startPulse,
  input  logic                 enable,
  input  logic                 hitValid,
  input  logic [2:0]           hitIdx,
  output logic [NUM_HOLES-1:0] molesActive,
  output logic                 moleSpawned,
  output logic                 moleExpired,
  output logic                 hitAck,
  output logic [2:0]           level
);

  import whack_pkg::*;

  localparam logic [15:0]          GAP_LAST = 16'(GAP_MS - 1);
  localparam logic [7:0]           HIT_LAST = 8'(HITS_PER_LEVEL - 1);
  localparam logic [2:0]           IDX_LAST = 3'(NUM_HOLES - 1);
  localparam logic [NUM_HOLES-1:0] ONE_HOT0 = NUM_HOLES'(1);

  logic                 tick_s;
  moleState_e           state_r, stateNext_s;
  logic [15:0]          lfsr_r, lfsrNext_s;
  logic [15:0]          gapCnt_r, gapCntNext_s;
  logic [11:0]          upCnt_r, upCntNext_s;
  logic [7:0]           hitCnt_r, hitCntNext_s;
  logic [2:0]           level_r, levelNext_s;
  logic [2:0]           prevIdx_r, prevIdxNext_s;
  logic [NUM_HOLES-1:0] moles_r, molesNext_s;
  logic                 spawned_r, spawnedNext_s;
  logic                 expired_r, expiredNext_s;
  logic                 ack_r, ackNext_s;
  logic [15:0]          levelDrop_s;
  logic [11:0]          upTime_s;
  logic [2:0]           rawIdx_s, spawnIdx_s;

  mole_tick_gen #(
    .DIV(CLK_HZ / TICK_HZ)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(startPulse),
    .tick (tick_s)
  );

  // Up-time for the current level, floored without ever underflowing.
  always_comb begin
    levelDrop_s = 16'(level_r) * 16'(STEP_MS);
    if ((levelDrop_s + 16'(MIN_UP_MS)) >= 16'(BASE_UP_MS)) begin
      upTime_s = 12'(MIN_UP_MS);
    end else begin
      upTime_s = 12'(16'(BASE_UP_MS) - levelDrop_s);
    end
  end

  // Hole choice for the next mole; bumps to the neighbour to avoid a repeat.
  always_comb begin
    rawIdx_s = 3'(lfsr_r % 16'(NUM_HOLES));
    if (rawIdx_s == prevIdx_r) begin
      if (rawIdx_s == IDX_LAST) begin
        spawnIdx_s = 3'd0;
      end else begin
        spawnIdx_s = rawIdx_s + 3'd1;
      end
    end else begin
      spawnIdx_s = rawIdx_s;
    end
  end

  // Next-state and next-output logic: startPulse, then !enable, then the FSM.
  always_comb begin
    stateNext_s   = state_r;
    lfsrNext_s    = lfsr_r;
    gapCntNext_s  = 16'd0;
    upCntNext_s   = upCnt_r;
    hitCntNext_s  = hitCnt_r;
    levelNext_s   = level_r;
    prevIdxNext_s = prevIdx_r;
    molesNext_s   = moles_r;
    spawnedNext_s = 1'b0;
    expiredNext_s = 1'b0;
    ackNext_s     = 1'b0;
    if (startPulse) begin
      stateNext_s   = GAP;
      lfsrNext_s    = LFSR_SEED;
      upCntNext_s   = 12'd0;
      hitCntNext_s  = 8'd0;
      levelNext_s   = 3'd0;
      prevIdxNext_s = 3'd0;
      molesNext_s   = {NUM_HOLES{1'b0}};
    end else if (!enable) begin
      stateNext_s = IDLE;
      molesNext_s = {NUM_HOLES{1'b0}};
    end else begin
      lfsrNext_s = lfsrStep(lfsr_r);
      case (state_r)
        IDLE: begin
          molesNext_s = {NUM_HOLES{1'b0}};
          stateNext_s = GAP;
        end
        GAP: begin
          if (tick_s) begin
            if (gapCnt_r == GAP_LAST) begin
              stateNext_s = SPAWN;
            end else begin
              gapCntNext_s = gapCnt_r + 16'd1;
            end
          end else begin
            gapCntNext_s = gapCnt_r;
          end
        end
        SPAWN: begin
          molesNext_s   = ONE_HOT0 << spawnIdx_s;
          prevIdxNext_s = spawnIdx_s;
          spawnedNext_s = 1'b1;
          upCntNext_s   = 12'd0;
          stateNext_s   = UP;
        end
        UP: begin
          if (hitValid && (hitIdx == prevIdx_r)) begin
            // A hit outranks an expiry landing in the same cycle.
            ackNext_s   = 1'b1;
            molesNext_s = {NUM_HOLES{1'b0}};
            stateNext_s = CLEAR;
            if (hitCnt_r == HIT_LAST) begin
              hitCntNext_s = 8'd0;
              if (level_r == 3'd7) begin
                levelNext_s = level_r;
              end else begin
                levelNext_s = level_r + 3'd1;
              end
            end else begin
              hitCntNext_s = hitCnt_r + 8'd1;
            end
          end else if (tick_s) begin
            if ((upCnt_r + 12'd1) >= upTime_s) begin
              expiredNext_s = 1'b1;
              molesNext_s   = {NUM_HOLES{1'b0}};
              stateNext_s   = CLEAR;
            end else begin
              upCntNext_s = upCnt_r + 12'd1;
            end
          end else begin
            upCntNext_s = upCnt_r;
          end
        end
        CLEAR: begin
          molesNext_s = {NUM_HOLES{1'b0}};
          stateNext_s = GAP;
        end
        default: begin
          molesNext_s = {NUM_HOLES{1'b0}};
          stateNext_s = IDLE;
        end
      endcase
    end
  end

  // State, counters, LFSR and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      lfsr_r    <= LFSR_SEED;
      gapCnt_r  <= 16'd0;
      upCnt_r   <= 12'd0;
      hitCnt_r  <= 8'd0;
      level_r   <= 3'd0;
      prevIdx_r <= 3'd0;
      moles_r   <= {NUM_HOLES{1'b0}};
      spawned_r <= 1'b0;
      expired_r <= 1'b0;
      ack_r     <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      lfsr_r    <= lfsrNext_s;
      gapCnt_r  <= gapCntNext_s;
      upCnt_r   <= upCntNext_s;
      hitCnt_r  <= hitCntNext_s;
      level_r   <= levelNext_s;
      prevIdx_r <= prevIdxNext_s;
      moles_r   <= molesNext_s;
      spawned_r <= spawnedNext_s;
      expired_r <= expiredNext_s;
      ack_r     <= ackNext_s;
    end
  end

  assign molesActive = moles_r;
  assign moleSpawned = spawned_r;
  assign moleExpired = expired_r;
  assign hitAck      = ack_r;
  assign level       = level_r;

endmodule
